// File: rtl/pad_bus_pkg.sv
// Shared types and constants for the pad bus initiator.
package pad_bus_pkg;

    // Transaction phases of the initiator
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WDAT = 3'd2,
        RDAT = 3'd3,
        RESP = 3'd4
    } state_e;

    // Bus direction encoding on AWRITEB / CMD_WRITEB / RSP_WRITEB
    localparam logic PADBUS_WRITE = 1'b0;
    localparam logic PADBUS_READ  = 1'b1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    // Width of the per-phase watchdog counter for a given timeout
    function automatic int wdog_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    localparam int WDOG_W_DEFAULT = wdog_width(TIMEOUT_CYCLES_DEFAULT);

endpackage

// File: rtl/pad_bus_watchdog.sv
// Per-phase watchdog shared by the ADDR, WDAT and RDAT phases.
// The count restarts on every phase entry (clear) and advances on every
// enabled cycle without a handshake. Expiry is flagged combinationally on
// the limit cycle so the FSM can drop the phase on the next edge; a
// handshake on that same cycle wins over expiry.
module pad_bus_watchdog
    import pad_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W          = wdog_width(TIMEOUT_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_hit,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Wait counter: restart on phase entry, advance while the handshake is missing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !i_hit) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_enable && !i_hit && (r_count == LIMIT);

endmodule

// File: rtl/pad_bus_master.sv
// Pad bus initiator: turns one outstanding write/read command into the
// address, write-data and read-data handshakes of the pad bus and returns
// exactly one response per command. Every bus and response output comes
// straight from a register; only CMD_READY and BUSY decode the state.
module pad_bus_master
    import pad_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITEB,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_WRITEB,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  BUSY,
    output logic                  AWRITEB,
    output logic [ADDR_WIDTH-1:0] AADDR,
    output logic                  AVALID,
    input  logic                  AREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int WDOG_W = wdog_width(TIMEOUT_CYCLES);

    state_e                r_state;
    logic                  r_awriteb;
    logic [ADDR_WIDTH-1:0] r_aaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_avalid;
    logic                  r_wvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic                  r_rsp_writeb;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    state_e                w_state_nx;
    logic                  w_awriteb_nx;
    logic [ADDR_WIDTH-1:0] w_aaddr_nx;
    logic [DATA_WIDTH-1:0] w_wdata_nx;
    logic                  w_avalid_nx;
    logic                  w_wvalid_nx;
    logic                  w_rready_nx;
    logic                  w_rsp_valid_nx;
    logic                  w_rsp_writeb_nx;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nx;
    logic                  w_rsp_err_nx;

    logic                  w_wd_clear;
    logic                  w_wd_enable;
    logic                  w_wd_hit;
    logic                  w_wd_expired;

    // Watchdog runs only in the three bus phases; the hit is that phase's handshake.
    // Each phase's own valid/ready is high for the whole phase, so the
    // responder-side signal alone marks the handshake.
    assign w_wd_enable = (r_state == ADDR) || (r_state == WDAT) || (r_state == RDAT);
    assign w_wd_hit    = ((r_state == ADDR) && AREADY) ||
                         ((r_state == WDAT) && WREADY) ||
                         ((r_state == RDAT) && RVALID);

    pad_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (WDOG_W)
    ) u_watchdog (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .i_hit     (w_wd_hit),
        .o_expired (w_wd_expired)
    );

    // Next-state and next-output decode for the transaction FSM
    always_comb begin
        w_state_nx      = r_state;
        w_awriteb_nx    = r_awriteb;
        w_aaddr_nx      = r_aaddr;
        w_wdata_nx      = r_wdata;
        w_avalid_nx     = r_avalid;
        w_wvalid_nx     = r_wvalid;
        w_rready_nx     = r_rready;
        w_rsp_valid_nx  = r_rsp_valid;
        w_rsp_writeb_nx = r_rsp_writeb;
        w_rsp_rdata_nx  = r_rsp_rdata;
        w_rsp_err_nx    = r_rsp_err;
        w_wd_clear      = 1'b0;

        case (r_state)
            IDLE: begin
                if (CMD_VALID) begin
                    w_awriteb_nx = CMD_WRITEB;
                    w_aaddr_nx   = CMD_ADDR;
                    w_wdata_nx   = CMD_WDATA;
                    w_avalid_nx  = 1'b1;
                    w_wd_clear   = 1'b1;
                    w_state_nx   = ADDR;
                end else begin
                    w_state_nx   = IDLE;
                end
            end

            ADDR: begin
                if (AREADY) begin
                    w_avalid_nx = 1'b0;
                    w_wd_clear  = 1'b1;
                    if (r_awriteb == PADBUS_READ) begin
                        w_rready_nx = 1'b1;
                        w_state_nx  = RDAT;
                    end else begin
                        w_wvalid_nx = 1'b1;
                        w_state_nx  = WDAT;
                    end
                end else if (w_wd_expired) begin
                    // Chip never took the address: skip the data phase entirely
                    w_avalid_nx     = 1'b0;
                    w_rsp_valid_nx  = 1'b1;
                    w_rsp_err_nx    = 1'b1;
                    w_rsp_rdata_nx  = '0;
                    w_rsp_writeb_nx = r_awriteb;
                    w_state_nx      = RESP;
                end else begin
                    w_state_nx = ADDR;
                end
            end

            WDAT: begin
                if (WREADY || w_wd_expired) begin
                    w_wvalid_nx     = 1'b0;
                    w_rsp_valid_nx  = 1'b1;
                    w_rsp_err_nx    = !WREADY;
                    w_rsp_rdata_nx  = '0;
                    w_rsp_writeb_nx = r_awriteb;
                    w_state_nx      = RESP;
                end else begin
                    w_state_nx = WDAT;
                end
            end

            RDAT: begin
                if (RVALID) begin
                    w_rready_nx     = 1'b0;
                    w_rsp_valid_nx  = 1'b1;
                    w_rsp_err_nx    = 1'b0;
                    w_rsp_rdata_nx  = RDATA;
                    w_rsp_writeb_nx = r_awriteb;
                    w_state_nx      = RESP;
                end else if (w_wd_expired) begin
                    w_rready_nx     = 1'b0;
                    w_rsp_valid_nx  = 1'b1;
                    w_rsp_err_nx    = 1'b1;
                    w_rsp_rdata_nx  = '0;
                    w_rsp_writeb_nx = r_awriteb;
                    w_state_nx      = RESP;
                end else begin
                    w_state_nx = RDAT;
                end
            end

            RESP: begin
                // No watchdog here: the host owns the response channel
                if (RSP_READY) begin
                    w_rsp_valid_nx = 1'b0;
                    w_state_nx     = IDLE;
                end else begin
                    w_state_nx     = RESP;
                end
            end

            default: begin
                w_avalid_nx    = 1'b0;
                w_wvalid_nx    = 1'b0;
                w_rready_nx    = 1'b0;
                w_rsp_valid_nx = 1'b0;
                w_state_nx     = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= IDLE;
            r_awriteb    <= 1'b0;
            r_aaddr      <= '0;
            r_wdata      <= '0;
            r_avalid     <= 1'b0;
            r_wvalid     <= 1'b0;
            r_rready     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_writeb <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_awriteb    <= w_awriteb_nx;
            r_aaddr      <= w_aaddr_nx;
            r_wdata      <= w_wdata_nx;
            r_avalid     <= w_avalid_nx;
            r_wvalid     <= w_wvalid_nx;
            r_rready     <= w_rready_nx;
            r_rsp_valid  <= w_rsp_valid_nx;
            r_rsp_writeb <= w_rsp_writeb_nx;
            r_rsp_rdata  <= w_rsp_rdata_nx;
            r_rsp_err    <= w_rsp_err_nx;
        end
    end

    assign CMD_READY  = (r_state == IDLE);
    assign BUSY       = (r_state != IDLE);
    assign AWRITEB    = r_awriteb;
    assign AADDR      = r_aaddr;
    assign AVALID     = r_avalid;
    assign WDATA      = r_wdata;
    assign WVALID     = r_wvalid;
    assign RREADY     = r_rready;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_WRITEB = r_rsp_writeb;
    assign RSP_RDATA  = r_rsp_rdata;
    assign RSP_ERR    = r_rsp_err;

endmodule

// File: tb/tb_pad_bus_master.sv
// Self-checking bench for pad_bus_master (TIMEOUT_CYCLES = 8).
// Expected behaviour is derived per transaction from phase delays:
// a phase whose handshake comes d cycles after it opens succeeds iff
// d <= TMO-1 and is then open d+1 cycles, otherwise it is open TMO cycles.
module tb_pad_bus_master;

    localparam int TMO = 8;

    logic       ACLK;
    logic       ARESET;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_WRITEB;
    logic [5:0] CMD_ADDR;
    logic [7:0] CMD_WDATA;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic       RSP_WRITEB;
    logic [7:0] RSP_RDATA;
    logic       RSP_ERR;
    logic       BUSY;
    logic       AWRITEB;
    logic [5:0] AADDR;
    logic       AVALID;
    logic       AREADY;
    logic [7:0] WDATA;
    logic       WVALID;
    logic       WREADY;
    logic [7:0] RDATA;
    logic       RVALID;
    logic       RREADY;

    int checks   = 0;
    int failures = 0;

    pad_bus_master #(
        .ADDR_WIDTH     (6),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_WRITEB (CMD_WRITEB),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_WDATA  (CMD_WDATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_WRITEB (RSP_WRITEB),
        .RSP_RDATA  (RSP_RDATA),
        .RSP_ERR    (RSP_ERR),
        .BUSY       (BUSY),
        .AWRITEB    (AWRITEB),
        .AADDR      (AADDR),
        .AVALID     (AVALID),
        .AREADY     (AREADY),
        .WDATA      (WDATA),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .RDATA      (RDATA),
        .RVALID     (RVALID),
        .RREADY     (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cmd();
        CMD_VALID  = 1'($urandom_range(0, 1));
        CMD_WRITEB = 1'($urandom_range(0, 1));
        CMD_ADDR   = 6'($urandom);
        CMD_WDATA  = 8'($urandom);
    endtask

    // One full command from IDLE back to IDLE. a_d/w_d/r_d are the cycles
    // the responder waits after the phase opens; rsp_d the response stall.
    task automatic run_txn(input logic wr_b, input logic [5:0] addr, input logic [7:0] wd,
                           input int a_d, input int w_d, input int r_d,
                           input logic [7:0] rd, input int rsp_d);
        int   na, nw, nr, cyc, bad_addr, bad_wd, overlap, bad_hold, p2_d;
        int   exp_na, exp_n2, exp_nw, exp_nr;
        bit   a_ok, p2_ok;
        logic [7:0] exp_rd;
        logic       h_wb, h_err;
        logic [7:0] h_rd;

        a_ok   = (a_d <= TMO - 1);
        p2_d   = wr_b ? r_d : w_d;
        p2_ok  = a_ok && (p2_d <= TMO - 1);
        exp_na = a_ok ? a_d + 1 : TMO;
        exp_n2 = !a_ok ? 0 : (p2_ok ? p2_d + 1 : TMO);
        exp_nw = wr_b ? 0 : exp_n2;
        exp_nr = wr_b ? exp_n2 : 0;
        exp_rd = (wr_b && p2_ok) ? rd : 8'h00;

        chk("cmd_ready_idle", CMD_READY, 1);
        CMD_VALID  = 1'b1;
        CMD_WRITEB = wr_b;
        CMD_ADDR   = addr;
        CMD_WDATA  = wd;
        RSP_READY  = 1'b0;
        @(negedge ACLK);

        na = 0; nw = 0; nr = 0; cyc = 0; bad_addr = 0; bad_wd = 0; overlap = 0;
        while (RSP_VALID !== 1'b1 && cyc < 200) begin
            if (AVALID && (WVALID || RREADY)) overlap++;
            if (AVALID) begin
                if (AADDR !== addr || AWRITEB !== wr_b) bad_addr++;
                AREADY = (na == a_d);
                na++;
            end else begin
                AREADY = 1'($urandom_range(0, 1));
            end
            if (WVALID) begin
                if (WDATA !== wd) bad_wd++;
                WREADY = (nw == w_d);
                nw++;
            end else begin
                WREADY = 1'($urandom_range(0, 1));
            end
            if (RREADY) begin
                RVALID = (nr == r_d);
                RDATA  = (nr == r_d) ? rd : 8'($urandom);
                nr++;
            end else begin
                RVALID = 1'($urandom_range(0, 1));
                RDATA  = 8'($urandom);
            end
            scramble_cmd();
            cyc++;
            @(negedge ACLK);
        end

        chk("rsp_valid_seen", RSP_VALID, 1);
        chk("avalid_cycles", na, exp_na);
        chk("wvalid_cycles", nw, exp_nw);
        chk("rready_cycles", nr, exp_nr);
        chk("rsp_latency", cyc, exp_na + exp_n2);
        chk("phase_overlap", overlap, 0);
        chk("aaddr_stable", bad_addr, 0);
        chk("wdata_stable", bad_wd, 0);
        chk("rsp_err", RSP_ERR, !p2_ok);
        chk("rsp_rdata", RSP_RDATA, exp_rd);
        chk("rsp_writeb", RSP_WRITEB, wr_b);
        chk("bus_idle_in_resp", {AVALID, WVALID, RREADY}, 3'b000);

        h_wb = RSP_WRITEB; h_err = RSP_ERR; h_rd = RSP_RDATA;
        bad_hold = 0;
        for (int i = 0; i < rsp_d; i++) begin
            RSP_READY = 1'b0;
            AREADY = 1'($urandom_range(0, 1));
            WREADY = 1'($urandom_range(0, 1));
            RVALID = 1'($urandom_range(0, 1));
            RDATA  = 8'($urandom);
            scramble_cmd();
            @(negedge ACLK);
            if (RSP_VALID !== 1'b1 || RSP_WRITEB !== h_wb || RSP_ERR !== h_err ||
                RSP_RDATA !== h_rd || CMD_READY !== 1'b0 || BUSY !== 1'b1) bad_hold++;
        end
        chk("rsp_hold_stable", bad_hold, 0);

        RSP_READY = 1'b1;
        @(negedge ACLK);
        RSP_READY = 1'b0;
        CMD_VALID = 1'b0;
        AREADY    = 1'b0;
        WREADY    = 1'b0;
        RVALID    = 1'b0;
        chk("rsp_valid_dropped", RSP_VALID, 0);
        chk("busy_after_rsp", BUSY, 0);
    endtask

    initial begin
        int bad_after_rst;
        ARESET     = 1'b1;
        CMD_VALID  = 1'b0;
        CMD_WRITEB = 1'b0;
        CMD_ADDR   = 6'h00;
        CMD_WDATA  = 8'h00;
        RSP_READY  = 1'b0;
        AREADY     = 1'b0;
        WREADY     = 1'b0;
        RDATA      = 8'h00;
        RVALID     = 1'b0;
        repeat (2) @(negedge ACLK);

        // Reset state
        chk("rst_bus_outs", {AVALID, WVALID, RREADY, AWRITEB, AADDR, WDATA}, 0);
        chk("rst_rsp_outs", {RSP_VALID, RSP_WRITEB, RSP_ERR, RSP_RDATA}, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cmd_ready", CMD_READY, 1);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Zero-wait write of 0x2A to 0x05
        run_txn(1'b0, 6'h05, 8'h2A, 0, 0, 0, 8'h00, 0);
        // Read of 0x3F with AREADY after 2 cycles and RVALID after 3
        run_txn(1'b1, 6'h3F, 8'h00, 2, 0, 3, 8'hC3, 0);
        // Response backpressure for 5 cycles, then back-to-back command
        run_txn(1'b0, 6'h11, 8'h99, 1, 1, 0, 8'h00, 5);
        run_txn(1'b1, 6'h22, 8'h00, 0, 0, 0, 8'h5C, 0);
        // Address phase never accepted
        run_txn(1'b0, 6'h0A, 8'h77, 1000, 0, 0, 8'h00, 1);
        // Read handshake on the limit cycle succeeds; one later times out
        run_txn(1'b1, 6'h01, 8'h00, 0, 0, TMO - 1, 8'h11, 0);
        run_txn(1'b1, 6'h02, 8'h00, 0, 0, TMO, 8'h22, 0);
        // Write data phase boundaries
        run_txn(1'b0, 6'h03, 8'hA5, TMO - 1, TMO - 1, 0, 8'h00, 0);
        run_txn(1'b0, 6'h04, 8'h5A, 0, TMO, 0, 8'h00, 2);

        // Reset while waiting in the write data phase
        CMD_VALID  = 1'b1;
        CMD_WRITEB = 1'b0;
        CMD_ADDR   = 6'h12;
        CMD_WDATA  = 8'h5A;
        AREADY     = 1'b1;
        WREADY     = 1'b0;
        @(negedge ACLK);
        CMD_VALID  = 1'b0;
        @(negedge ACLK);
        chk("rst_pre_wvalid", WVALID, 1);
        AREADY = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        chk("rst_mid_wvalid", WVALID, 0);
        chk("rst_mid_outs", {AVALID, RREADY, AWRITEB, AADDR, WDATA, RSP_VALID, RSP_ERR, RSP_RDATA}, 0);
        chk("rst_mid_idle", {BUSY, CMD_READY}, 2'b01);
        bad_after_rst = 0;
        for (int i = 0; i < 3; i++) begin
            WREADY = 1'b1;
            @(negedge ACLK);
            if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) bad_after_rst++;
        end
        WREADY = 1'b0;
        chk("rst_no_response", bad_after_rst, 0);
        run_txn(1'b0, 6'h12, 8'h5A, 0, 0, 0, 8'h00, 0);

        // Randomized traffic covering both directions and both outcomes
        for (int t = 0; t < 40; t++) begin
            logic       r_wr;
            logic [5:0] r_ad;
            logic [7:0] r_wd, r_rd;
            r_wr = 1'($urandom_range(0, 1));
            r_ad = 6'($urandom);
            r_wd = 8'($urandom);
            r_rd = 8'($urandom);
            run_txn(r_wr, r_ad, r_wd, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), r_rd, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
